ir_nec_tx: RTL

NEC-protocol infrared transmitter, the transmit counterpart to the team's infrared_rec_v3 receiver. It accepts an 8-bit address and an 8-bit command through a start pulse. It serialises a full NEC frame onto an active-low IR line: leader, then addr, ~addr, cmd, ~cmd (each LSB first), then a stop mark. It drives an IR LED driver, or loops back directly into the receiver for self-test.

---
 rtl/ir_nec_pkg.sv | 32 +++
 rtl/ir_nec_tx_if.sv | 28 ++
 rtl/ir_us_tick.sv | 39 +++
 rtl/ir_nec_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg
// Shared NEC infrared protocol definitions: phase durations in microseconds,
// the transmitter state encoding, the frame width, and a small helper that
// tells which states drive a mark (IR line low / carrier on).
// No ports; imported with `import ir_nec_pkg::*;`.

package ir_nec_pkg;

    localparam int LEAD_MARK_US  = 9000;
    localparam int LEAD_SPACE_US = 4500;
    localparam int BIT_MARK_US   = 560;
    localparam int ZERO_SPACE_US = 560;
    localparam int ONE_SPACE_US  = 1680;
    localparam int STOP_MARK_US  = 560;

    // addr, ~addr, cmd, ~cmd
    localparam int FRAME_BITS = 32;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5
    } nec_state_e;

    function automatic logic is_mark(input logic [2:0] st);
        return (st == LEAD_MARK) || (st == BIT_MARK) || (st == STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_nec_tx_if.sv
// ir_nec_tx_if
// Request/status bundle of the NEC transmitter.
//   tx_start : single-cycle request to send one frame
//   addr     : 8-bit address, sampled when tx_start is accepted
//   cmd      : 8-bit command, sampled when tx_start is accepted
//   ir_out   : IR line, idle high, mark low
//   busy     : high while a frame is in progress
//   done     : one-cycle pulse when a frame completes
// master = requester side, slave = transmitter side.

interface ir_nec_tx_if;
    logic       tx_start;
    logic [7:0] addr;
    logic [7:0] cmd;
    logic       ir_out;
    logic       busy;
    logic       done;

    modport master (
        output tx_start, addr, cmd,
        input  ir_out, busy, done
    );

    modport slave (
        input  tx_start, addr, cmd,
        output ir_out, busy, done
    );
endinterface

// File: rtl/ir_us_tick.sv
// ir_us_tick
// Microsecond prescaler: divides clk by DIV and raises tick for one cycle
// every DIV clocks. A synchronous clr restarts the count so that the first
// tick after a clear arrives exactly DIV clocks later.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous restart of the prescaler
//   tick  : one-cycle pulse, period DIV clocks

module ir_us_tick #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Tick is not gated by clr: the owner uses tick to decide the phase end
    // that itself raises clr, so gating would close a combinational loop.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/ir_nec_tx.sv
// ir_nec_tx
// NEC infrared transmitter. On an accepted tx_start it sends leader,
// addr, ~addr, cmd, ~cmd (each LSB first) and a stop mark on an active-low
// IR line, then pulses done. Phase lengths are counted in microseconds from
// ir_us_tick; prescaler and us counter restart on every state entry.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ir_nec_tx_if.slave (tx_start, addr, cmd, ir_out, busy, done)
// Build option: define IR_CARRIER_EN to modulate marks with a 50% duty
// square wave at CARRIER_FREQ (starting low at each mark). Without it the
// marks are constant low (baseband, suitable for receiver loopback).
// The *_T parameters default to the NEC timings and exist so that a
// faster-running instance can be built for bring-up.

module ir_nec_tx
    import ir_nec_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int CARRIER_FREQ = 38_000,
    parameter int LEAD_MARK_T  = LEAD_MARK_US,
    parameter int LEAD_SPACE_T = LEAD_SPACE_US,
    parameter int BIT_MARK_T   = BIT_MARK_US,
    parameter int ZERO_SPACE_T = ZERO_SPACE_US,
    parameter int ONE_SPACE_T  = ONE_SPACE_US,
    parameter int STOP_MARK_T  = STOP_MARK_US
) (
    input logic        clk,
    input logic        rst_n,
    ir_nec_tx_if.slave bus
);

    localparam int US_DIV = CLK_FREQ / 1_000_000;

    localparam logic [2:0] ST_IDLE       = IDLE;
    localparam logic [2:0] ST_LEAD_MARK  = LEAD_MARK;
    localparam logic [2:0] ST_LEAD_SPACE = LEAD_SPACE;
    localparam logic [2:0] ST_BIT_MARK   = BIT_MARK;
    localparam logic [2:0] ST_BIT_SPACE  = BIT_SPACE;
    localparam logic [2:0] ST_STOP_MARK  = STOP_MARK;

    logic [2:0]            state;
    logic [2:0]            state_nx;
    logic [13:0]           us_cnt;
    logic [13:0]           phase_len;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  tick;
    logic                  phase_end;
    logic                  accept;
    logic                  state_chg;
    logic                  prescale_clr;
    logic                  mark_nx;
    logic                  ir_out_nx;
    logic                  ir_out_q;
    logic                  busy_q;
    logic                  done_q;

    ir_us_tick #(.DIV(US_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (prescale_clr),
        .tick  (tick)
    );

    always_comb begin
        phase_len = 14'd1;
        case (state)
            ST_LEAD_MARK:  phase_len = 14'(LEAD_MARK_T);
            ST_LEAD_SPACE: phase_len = 14'(LEAD_SPACE_T);
            ST_BIT_MARK:   phase_len = 14'(BIT_MARK_T);
            ST_BIT_SPACE:  phase_len = shreg[0] ? 14'(ONE_SPACE_T) : 14'(ZERO_SPACE_T);
            ST_STOP_MARK:  phase_len = 14'(STOP_MARK_T);
            default:       phase_len = 14'd1;
        endcase
    end

    // The phase ends on the tick that completes its last microsecond.
    assign phase_end = (state != ST_IDLE) && tick && (us_cnt == phase_len - 14'd1);
    assign accept    = (state == ST_IDLE) && bus.tx_start;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:       if (bus.tx_start) state_nx = ST_LEAD_MARK;
            ST_LEAD_MARK:  if (phase_end) state_nx = ST_LEAD_SPACE;
            ST_LEAD_SPACE: if (phase_end) state_nx = ST_BIT_MARK;
            ST_BIT_MARK:   if (phase_end) state_nx = ST_BIT_SPACE;
            ST_BIT_SPACE:
                if (phase_end) begin
                    state_nx = (bit_cnt == 6'(FRAME_BITS - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
                end
            ST_STOP_MARK:  if (phase_end) state_nx = ST_IDLE;
            default:       state_nx = ST_IDLE;
        endcase
    end

    // Every transition changes the state code, so a code change marks an entry.
    assign state_chg    = (state_nx != state);
    assign prescale_clr = state_chg || (state == ST_IDLE);
    assign mark_nx      = is_mark(state_nx);

`ifdef IR_CARRIER_EN
    localparam int CAR_PERIOD = CLK_FREQ / CARRIER_FREQ;
    localparam int CAR_CW     = (CAR_PERIOD > 1) ? $clog2(CAR_PERIOD) : 1;
    localparam logic [CAR_CW-1:0] CAR_LAST = CAR_CW'(CAR_PERIOD - 1);
    localparam logic [CAR_CW-1:0] CAR_HALF = CAR_CW'(CAR_PERIOD / 2);

    logic [CAR_CW-1:0] car_cnt;
    logic [CAR_CW-1:0] car_cnt_nx;

    // Carrier phase restarts at each mark entry so every mark begins low.
    always_comb begin
        if (!mark_nx || state_chg || (car_cnt == CAR_LAST)) begin
            car_cnt_nx = '0;
        end else begin
            car_cnt_nx = car_cnt + 1'b1;
        end
        ir_out_nx = mark_nx ? (car_cnt_nx >= CAR_HALF) : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_cnt <= '0;
        end else begin
            car_cnt <= car_cnt_nx;
        end
    end
`else
    assign ir_out_nx = ~mark_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            us_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ir_out_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state <= state_nx;

            if (prescale_clr) begin
                us_cnt <= '0;
            end else if (tick) begin
                us_cnt <= us_cnt + 14'd1;
            end

            if (accept) begin
                shreg   <= {~bus.cmd, bus.cmd, ~bus.addr, bus.addr};
                bit_cnt <= '0;
            end else if ((state == ST_BIT_SPACE) && phase_end) begin
                shreg   <= {1'b0, shreg[FRAME_BITS-1:1]};
                bit_cnt <= bit_cnt + 6'd1;
            end

            // Outputs are registered from the next state so they change on
            // the same edge as the state and never glitch.
            ir_out_q <= ir_out_nx;
            busy_q   <= (state_nx != ST_IDLE);
            done_q   <= (state == ST_STOP_MARK) && phase_end;
        end
    end

    assign bus.ir_out = ir_out_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule
